// File: rtl/demux_14_buf.sv
// Buffered 1-to-4 demultiplexer: steers a valid/ready word stream into four
// independent 2-entry FIFOs, each with its own handshake and delivered-word counter.
module demux_14_buf #(
    parameter int W  = 1,
    parameter int CW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_data,
    input  logic [1:0]        sel,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [4*W-1:0]    out_data,
    output logic [4*CW-1:0]   out_count
);

    localparam logic [1:0] DEPTH = 2'd2;

    logic [1:0]    occ  [4];
    logic          wptr [4];
    logic          rptr [4];
    logic [CW-1:0] cnt  [4];
    logic [W-1:0]  mem  [4][2];

    logic [3:0]    push;
    logic [3:0]    pop;

    // Occupancy moves by +1 on push only, -1 on pop only, and holds otherwise.
    function automatic logic [1:0] occ_next(input logic [1:0] cur,
                                            input logic       wr,
                                            input logic       rd);
        logic [1:0] nxt;
        nxt = cur;
        if (wr && !rd)
            nxt = cur + 2'd1;
        else if (rd && !wr)
            nxt = cur - 2'd1;
        return nxt;
    endfunction

    // in_ready looks only at registered occupancy, never at out_ready.
    assign in_ready = (occ[sel] != DEPTH);

    always_comb begin
        push = 4'b0000;
        if (in_valid && in_ready)
            push[sel] = 1'b1;
    end

    always_comb begin
        pop       = 4'b0000;
        out_valid = 4'b0000;
        out_data  = '0;
        out_count = '0;
        for (int k = 0; k < 4; k++) begin
            out_valid[k]           = (occ[k] != 2'd0);
            pop[k]                 = out_valid[k] && out_ready[k];
            out_data[k*W +: W]     = out_valid[k] ? mem[k][rptr[k]] : '0;
            out_count[k*CW +: CW]  = cnt[k];
        end
    end

    // Control state: pointers, occupancy and counters, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                occ[k]  <= 2'd0;
                wptr[k] <= 1'b0;
                rptr[k] <= 1'b0;
                cnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                occ[k] <= occ_next(occ[k], push[k], pop[k]);
                if (push[k])
                    wptr[k] <= ~wptr[k];
                if (pop[k]) begin
                    rptr[k] <= ~rptr[k];
                    cnt[k]  <= cnt[k] + 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: out_data is masked while a channel is empty.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (push[k])
                mem[k][wptr[k]] <= in_data;
        end
    end

endmodule

// File: tb/tb_demux_14_buf.sv
// Directed bench for demux_14_buf: table of per-cycle vectors plus
// hand-written reset and counter-wrap sequences.
module tb_demux_14_buf;

    localparam int W  = 1;
    localparam int CW = 8;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_data;
    logic [1:0]      sel;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [4*W-1:0]  out_data;
    logic [4*CW-1:0] out_count;

    int n_total = 0;
    int n_pass  = 0;

    demux_14_buf #(.W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [1:0]  sl;
        logic        d;
        logic [3:0]  ordy;
        logic        e_ir;
        logic [3:0]  e_ov;
        logic [3:0]  e_od;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic iv, input logic [1:0] sl, input logic d,
                                input logic [3:0] ordy, input logic e_ir,
                                input logic [3:0] e_ov, input logic [3:0] e_od,
                                input logic [31:0] e_cnt);
        vec_t v;
        v.iv = iv; v.sl = sl; v.d = d; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    initial begin
        int guard;
        int pops;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        sel       = 2'd0;
        out_ready = 4'b0000;

        // Reset state while held
        repeat (2) @(negedge clk);
        #1;
        chk("reset ov", 64'(out_valid), 64'h0);
        chk("reset cnt", 64'(out_count), 64'h0);
        chk("reset ir", 64'(in_ready), 64'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // iv, sel, d, out_ready | in_ready, out_valid, out_data(valid bits), counts {c3,c2,c1,c0}
        // select sweep
        tbl.push_back(mk(1, 0, 1, 4'b1111, 1, 4'b0000, 4'b0000, 32'h00000000));
        tbl.push_back(mk(1, 1, 0, 4'b1111, 1, 4'b0001, 4'b0001, 32'h00000000));
        tbl.push_back(mk(1, 2, 1, 4'b1111, 1, 4'b0010, 4'b0000, 32'h00000001));
        tbl.push_back(mk(1, 3, 1, 4'b1111, 1, 4'b0100, 4'b0100, 32'h00000101));
        tbl.push_back(mk(0, 0, 0, 4'b1111, 1, 4'b1000, 4'b1000, 32'h00010101));
        tbl.push_back(mk(0, 0, 0, 4'b1111, 1, 4'b0000, 4'b0000, 32'h01010101));
        // back-pressure on channel 1
        tbl.push_back(mk(1, 1, 1, 4'b1101, 1, 4'b0000, 4'b0000, 32'h01010101));
        tbl.push_back(mk(1, 1, 0, 4'b1101, 1, 4'b0010, 4'b0010, 32'h01010101));
        tbl.push_back(mk(1, 1, 1, 4'b1101, 0, 4'b0010, 4'b0010, 32'h01010101));
        tbl.push_back(mk(1, 1, 1, 4'b1111, 0, 4'b0010, 4'b0010, 32'h01010101));
        tbl.push_back(mk(1, 1, 1, 4'b1111, 1, 4'b0010, 4'b0000, 32'h01010201));
        tbl.push_back(mk(0, 0, 0, 4'b1111, 1, 4'b0010, 4'b0010, 32'h01010301));
        tbl.push_back(mk(0, 0, 0, 4'b1111, 1, 4'b0000, 4'b0000, 32'h01010401));
        // isolation: channel 3 full and stalled, sel alternates 0/3
        tbl.push_back(mk(1, 3, 0, 4'b0111, 1, 4'b0000, 4'b0000, 32'h01010401));
        tbl.push_back(mk(1, 3, 1, 4'b0111, 1, 4'b1000, 4'b0000, 32'h01010401));
        tbl.push_back(mk(1, 0, 1, 4'b0111, 1, 4'b1000, 4'b0000, 32'h01010401));
        tbl.push_back(mk(1, 3, 0, 4'b0111, 0, 4'b1001, 4'b0001, 32'h01010401));
        tbl.push_back(mk(1, 0, 0, 4'b0111, 1, 4'b1000, 4'b0000, 32'h01010402));
        tbl.push_back(mk(1, 3, 1, 4'b0111, 0, 4'b1001, 4'b0000, 32'h01010402));
        tbl.push_back(mk(1, 0, 1, 4'b0111, 1, 4'b1000, 4'b0000, 32'h01010403));
        tbl.push_back(mk(0, 0, 0, 4'b0111, 1, 4'b1001, 4'b0001, 32'h01010403));
        tbl.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b1000, 4'b0000, 32'h01010404));
        tbl.push_back(mk(0, 0, 0, 4'b1000, 1, 4'b1000, 4'b0000, 32'h01010404));
        tbl.push_back(mk(0, 0, 0, 4'b1000, 1, 4'b1000, 4'b1000, 32'h02010404));
        tbl.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b0000, 4'b0000, 32'h03010404));
        // simultaneous push/pop on channel 0 at occupancy 1
        tbl.push_back(mk(1, 0, 1, 4'b0000, 1, 4'b0000, 4'b0000, 32'h03010404));
        tbl.push_back(mk(1, 0, 0, 4'b0001, 1, 4'b0001, 4'b0001, 32'h03010404));
        tbl.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b0001, 4'b0000, 32'h03010405));
        tbl.push_back(mk(0, 0, 0, 4'b0001, 1, 4'b0001, 4'b0000, 32'h03010405));
        tbl.push_back(mk(0, 0, 0, 4'b0000, 1, 4'b0000, 4'b0000, 32'h03010406));

        foreach (tbl[i]) begin
            @(negedge clk);
            in_valid  = tbl[i].iv;
            sel       = tbl[i].sl;
            in_data   = tbl[i].d;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("row%0d ir", i), 64'(in_ready), 64'(tbl[i].e_ir));
            chk($sformatf("row%0d ov", i), 64'(out_valid), 64'(tbl[i].e_ov));
            chk($sformatf("row%0d od", i), 64'(out_data & tbl[i].e_ov), 64'(tbl[i].e_od & tbl[i].e_ov));
            chk($sformatf("row%0d cnt", i), 64'(out_count), 64'(tbl[i].e_cnt));
        end

        // Counter wrap on channel 2: it holds 1 pop already, stream 254 more, then one last
        @(negedge clk);
        in_valid  = 1'b1;
        sel       = 2'd2;
        in_data   = 1'b1;
        out_ready = 4'b0100;
        pops  = 0;
        guard = 0;
        while (pops < 254 && guard < 1000) begin
            @(negedge clk);
            #1;
            guard++;
            if (out_valid[2])
                pops++;
        end
        if (pops < 254)
            chk("wrap stream timeout", 64'(pops), 64'd254);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        #1;
        chk("wrap cnt 255", 64'(out_count), 64'h03FF0406);
        chk("wrap ov held", 64'(out_valid), 64'h4);
        out_ready = 4'b0100;
        @(negedge clk);
        out_ready = 4'b0000;
        #1;
        chk("wrap cnt 0", 64'(out_count), 64'h03000406);
        chk("wrap ov empty", 64'(out_valid), 64'h0);

        // Reset mid-stream with channel 2 holding two words
        @(negedge clk);
        in_valid = 1'b1;
        sel      = 2'd2;
        in_data  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("prerst ir full", 64'(in_ready), 64'h0);
        chk("prerst ov", 64'(out_valid), 64'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst ov", 64'(out_valid), 64'h0);
        chk("async rst cnt", 64'(out_count), 64'h0);
        chk("async rst od", 64'(out_data), 64'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("postrst ir", 64'(in_ready), 64'h1);
        chk("postrst ov", 64'(out_valid), 64'h0);
        chk("postrst cnt", 64'(out_count), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
